// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions for the scan-doubled output path:
// default 640x480@60 constants, total-count helpers and the 3:3:3 pixel type.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int CNT_W = 12;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb333_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Halve every channel; used to darken alternate doubled lines.
  function automatic rgb333_t scanline_dim(input rgb333_t px);
    rgb333_t d;
    d.r = px.r >> 1;
    d.g = px.g >> 1;
    d.b = px.b >> 1;
    return d;
  endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// Stage-0 raster generator: horizontal/vertical counters and the decodes
// that belong to the same cycle (raw syncs, active area, frame start).
// Decodes are computed from the next count and registered with it so every
// stage-0 output is a flop and reset cleanly drives them all to 0.
module vga_raster_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        pixclk,
  input  logic        reset,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start
);

  localparam logic [11:0] H_LAST   = 12'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [11:0] V_LAST   = 12'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] hcount_r, vcount_r;
  logic        hsync_r, vsync_r, active_r, frame_start_r;
  logic [11:0] hcount_nxt_s, vcount_nxt_s;
  logic        hsync_nxt_s, vsync_nxt_s, active_nxt_s, frame_start_nxt_s;

  // Next raster position and the decodes of that position.
  always_comb begin
    hcount_nxt_s = hcount_r + 12'd1;
    vcount_nxt_s = vcount_r;
    if (hcount_r == H_LAST) begin
      hcount_nxt_s = 12'd0;
      if (vcount_r == V_LAST) begin
        vcount_nxt_s = 12'd0;
      end else begin
        vcount_nxt_s = vcount_r + 12'd1;
      end
    end else begin
      vcount_nxt_s = vcount_r;
    end
    hsync_nxt_s       = (hcount_nxt_s >= HS_START) && (hcount_nxt_s < HS_END);
    vsync_nxt_s       = (vcount_nxt_s >= VS_START) && (vcount_nxt_s < VS_END);
    active_nxt_s      = (hcount_nxt_s < H_ACT) && (vcount_nxt_s < V_ACT);
    frame_start_nxt_s = (hcount_nxt_s == 12'd0) && (vcount_nxt_s == 12'd0);
  end

  // Stage-0 state: counters plus their registered decodes.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      hcount_r      <= 12'd0;
      vcount_r      <= 12'd0;
      hsync_r       <= 1'b0;
      vsync_r       <= 1'b0;
      active_r      <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      hcount_r      <= hcount_nxt_s;
      vcount_r      <= vcount_nxt_s;
      hsync_r       <= hsync_nxt_s;
      vsync_r       <= vsync_nxt_s;
      active_r      <= active_nxt_s;
      frame_start_r <= frame_start_nxt_s;
    end
  end

  assign hcount      = hcount_r;
  assign vcount      = vcount_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign active      = active_r;
  assign frame_start = frame_start_r;

endmodule

// File: rtl/vga_scan_out.sv
// VGA output stage of the scan-doubled path. Runs the raster counters that
// address the line buffer, then aligns syncs/blanking with the line buffer's
// one-clock-late pixel data so every pin is exactly 2 clocks behind stage 0.
// Optional: define SCANLINE_EN to halve the colour on odd raster lines.
module vga_scan_out
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        pixclk,
  input  logic        reset,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  output logic        hsync,
  output logic        vsync,
  input  logic [2:0]  red_in,
  input  logic [2:0]  grn_in,
  input  logic [2:0]  blu_in,
  output logic [2:0]  vga_r,
  output logic [2:0]  vga_g,
  output logic [2:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank,
  output logic        frame_start
);

  logic    active_s;
  logic    hsync_d1_r, vsync_d1_r, active_d1_r;
  rgb333_t pix_in_s, pix_s;
  rgb333_t vga_rgb_r;
  logic    vga_hsync_r, vga_vsync_r, vga_blank_r;
`ifdef SCANLINE_EN
  logic    vline_d1_r;
`endif

  vga_raster_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_raster (
    .pixclk      (pixclk),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync       (hsync),
    .vsync       (vsync),
    .active      (active_s),
    .frame_start (frame_start)
  );

  // Colour for the pixel arriving from the line buffer, dimmed on odd lines when enabled.
  always_comb begin
    pix_in_s = {red_in, grn_in, blu_in};
`ifdef SCANLINE_EN
    if (vline_d1_r) begin
      pix_s = scanline_dim(pix_in_s);
    end else begin
      pix_s = pix_in_s;
    end
`else
    pix_s = pix_in_s;
`endif
  end

  // First delay stage: match the line buffer's one-clock read latency.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      hsync_d1_r  <= 1'b0;
      vsync_d1_r  <= 1'b0;
      active_d1_r <= 1'b0;
`ifdef SCANLINE_EN
      vline_d1_r  <= 1'b0;
`endif
    end else begin
      hsync_d1_r  <= hsync;
      vsync_d1_r  <= vsync;
      active_d1_r <= active_s;
`ifdef SCANLINE_EN
      vline_d1_r  <= vcount[0];
`endif
    end
  end

  // Second stage: pin registers with blanking and sync polarity applied.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      vga_rgb_r   <= '0;
      vga_blank_r <= 1'b1;
      vga_hsync_r <= ~SYNC_POL;
      vga_vsync_r <= ~SYNC_POL;
    end else begin
      if (active_d1_r) begin
        vga_rgb_r   <= pix_s;
        vga_blank_r <= 1'b0;
      end else begin
        vga_rgb_r   <= '0;
        vga_blank_r <= 1'b1;
      end
      vga_hsync_r <= hsync_d1_r ^ ~SYNC_POL;
      vga_vsync_r <= vsync_d1_r ^ ~SYNC_POL;
    end
  end

  assign vga_r     = vga_rgb_r.r;
  assign vga_g     = vga_rgb_r.g;
  assign vga_b     = vga_rgb_r.b;
  assign vga_blank = vga_blank_r;
  assign vga_hsync = vga_hsync_r;
  assign vga_vsync = vga_vsync_r;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out. Instance a uses default 800x525 timing (horizontal
// behaviour over the first lines); instance b uses a tiny 24x13 raster with
// active-high syncs so whole frames, vsync and mid-frame reset fit in the run.
module tb_vga_scan_out;

  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rec_t;

  localparam rec_t IDLE = '0;

  logic        pixclk = 1'b0;
  logic        reset;
  logic [11:0] hc_a, vc_a, hc_b, vc_b;
  logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
  logic [2:0]  ri_a, gi_a, bi_a, ri_b, gi_b, bi_b;
  logic [2:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        vhs_a, vvs_a, blk_a, vhs_b, vvs_b, blk_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int   ma_h, ma_v, mb_h, mb_v;
  logic ma_fs, mb_fs;
  rec_t a_s0, a_d1, a_out, b_s0, b_d1, b_out;

  always #5 pixclk = ~pixclk;

  vga_scan_out dut_a (
    .pixclk (pixclk), .reset (reset),
    .hcount (hc_a), .vcount (vc_a), .hsync (hs_a), .vsync (vs_a),
    .red_in (ri_a), .grn_in (gi_a), .blu_in (bi_a),
    .vga_r (r_a), .vga_g (g_a), .vga_b (b_a),
    .vga_hsync (vhs_a), .vga_vsync (vvs_a), .vga_blank (blk_a),
    .frame_start (fs_a)
  );

  vga_scan_out #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6),  .V_FP (2), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b1)
  ) dut_b (
    .pixclk (pixclk), .reset (reset),
    .hcount (hc_b), .vcount (vc_b), .hsync (hs_b), .vsync (vs_b),
    .red_in (ri_b), .grn_in (gi_b), .blu_in (bi_b),
    .vga_r (r_b), .vga_g (g_b), .vga_b (b_b),
    .vga_hsync (vhs_b), .vga_vsync (vvs_b), .vga_blank (blk_b),
    .frame_start (fs_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // Expected stage-0 view of default timing; red follows hcount[2:0], g/b constant 5/2.
  function automatic rec_t dec_a(input int h, input int v);
    rec_t x;
    x.act = (h < 640) && (v < 480);
    x.hs  = (h >= 656) && (h < 752);
    x.vs  = (v >= 490) && (v < 492);
    x.r   = x.act ? 3'(h % 8) : 3'd0;
    x.g   = x.act ? 3'd5 : 3'd0;
    x.b   = x.act ? 3'd2 : 3'd0;
`ifdef SCANLINE_EN
    if (v % 2 == 1) begin
      x.r = x.r >> 1;
      x.g = x.g >> 1;
      x.b = x.b >> 1;
    end
`endif
    return x;
  endfunction

  // Expected stage-0 view of the tiny raster; input colour is constant 7/6/5.
  function automatic rec_t dec_b(input int h, input int v);
    rec_t x;
    x.act = (h < 16) && (v < 6);
    x.hs  = (h >= 18) && (h < 21);
    x.vs  = (v >= 8) && (v < 10);
    x.r   = x.act ? 3'd7 : 3'd0;
    x.g   = x.act ? 3'd6 : 3'd0;
    x.b   = x.act ? 3'd5 : 3'd0;
`ifdef SCANLINE_EN
    if (x.act && (v % 2 == 1)) begin
      x.r = 3'd3;
      x.g = 3'd3;
      x.b = 3'd2;
    end
`endif
    return x;
  endfunction

  task automatic compare_all();
    check("hcount_a", 32'(hc_a), 32'(ma_h));
    check("vcount_a", 32'(vc_a), 32'(ma_v));
    check("hsync_a", 32'(hs_a), 32'(a_s0.hs));
    check("vsync_a", 32'(vs_a), 32'(a_s0.vs));
    check("fstart_a", 32'(fs_a), 32'(ma_fs));
    check("vga_r_a", 32'(r_a), 32'(a_out.r));
    check("vga_g_a", 32'(g_a), 32'(a_out.g));
    check("vga_b_a", 32'(b_a), 32'(a_out.b));
    check("blank_a", 32'(blk_a), 32'(!a_out.act));
    check("vga_hs_a", 32'(vhs_a), 32'(!a_out.hs));
    check("vga_vs_a", 32'(vvs_a), 32'(!a_out.vs));
    check("hcount_b", 32'(hc_b), 32'(mb_h));
    check("vcount_b", 32'(vc_b), 32'(mb_v));
    check("hsync_b", 32'(hs_b), 32'(b_s0.hs));
    check("vsync_b", 32'(vs_b), 32'(b_s0.vs));
    check("fstart_b", 32'(fs_b), 32'(mb_fs));
    check("vga_r_b", 32'(r_b), 32'(b_out.r));
    check("vga_g_b", 32'(g_b), 32'(b_out.g));
    check("vga_b_b", 32'(b_b), 32'(b_out.b));
    check("blank_b", 32'(blk_b), 32'(!b_out.act));
    check("vga_hs_b", 32'(vhs_b), 32'(b_out.hs));
    check("vga_vs_b", 32'(vvs_b), 32'(b_out.vs));
  endtask

  // One clock: advance the expected model, play the line buffer, then check at negedge.
  task automatic tick();
    logic       rst_edge;
    logic [2:0] lb_r;
    rst_edge = reset;
    lb_r = hc_a[2:0];
    @(posedge pixclk);
    if (rst_edge) begin
      ma_h = 0; ma_v = 0; mb_h = 0; mb_v = 0;
      ma_fs = 1'b0; mb_fs = 1'b0;
      a_s0 = IDLE; a_d1 = IDLE; a_out = IDLE;
      b_s0 = IDLE; b_d1 = IDLE; b_out = IDLE;
    end else begin
      a_out = a_d1; a_d1 = a_s0;
      b_out = b_d1; b_d1 = b_s0;
      if (ma_h == 799) begin
        ma_h = 0;
        ma_v = (ma_v == 524) ? 0 : ma_v + 1;
      end else begin
        ma_h = ma_h + 1;
      end
      if (mb_h == 23) begin
        mb_h = 0;
        mb_v = (mb_v == 12) ? 0 : mb_v + 1;
      end else begin
        mb_h = mb_h + 1;
      end
      a_s0 = dec_a(ma_h, ma_v);
      b_s0 = dec_b(mb_h, mb_v);
      ma_fs = (ma_h == 0) && (ma_v == 0);
      mb_fs = (mb_h == 0) && (mb_v == 0);
    end
    #1;
    ri_a = lb_r;
    @(negedge pixclk);
    cyc++;
    compare_all();
  endtask

  initial begin
    int hs_cnt;
    int vlow_cnt;
    int first_low;
    int fs_cnt;
    int waited;
    reset = 1'b1;
    ri_a = 3'd0; gi_a = 3'd5; bi_a = 3'd2;
    ri_b = 3'd7; gi_b = 3'd6; bi_b = 3'd5;
    ma_h = 0; ma_v = 0; mb_h = 0; mb_v = 0;
    ma_fs = 1'b0; mb_fs = 1'b0;
    a_s0 = IDLE; a_d1 = IDLE; a_out = IDLE;
    b_s0 = IDLE; b_d1 = IDLE; b_out = IDLE;
    @(negedge pixclk);
    repeat (3) tick();

    // Reset values on the pins.
    check("rst_blank_a", 32'(blk_a), 32'd1);
    check("rst_vga_hs_a", 32'(vhs_a), 32'd1);
    check("rst_vga_hs_b", 32'(vhs_b), 32'd0);
    check("rst_fstart_a", 32'(fs_a), 32'd0);

    reset = 1'b0;
    hs_cnt = 0; vlow_cnt = 0; first_low = -1; fs_cnt = 0;
    for (int i = 1; i <= 1700; i++) begin
      tick();
      if (i <= 800 && hs_a) hs_cnt++;
      if (i >= 3 && i <= 802 && !vhs_a) begin
        vlow_cnt++;
        if (first_low < 0) first_low = i;
      end
      if (i <= 624 && fs_b) fs_cnt++;
      if (i == 800) begin
        check("wrap_h_a", 32'(hc_a), 32'd0);
        check("wrap_v_a", 32'(vc_a), 32'd1);
      end
    end
    check("hsync_width_a", 32'(hs_cnt), 32'd96);
    check("pin_hsync_low_a", 32'(vlow_cnt), 32'd96);
    check("pin_hsync_first_a", 32'(first_low), 32'd658);
    check("frame_pulses_b", 32'(fs_cnt), 32'd2);

    // Mid-frame reset on the tiny raster at hcount=10, vcount=3.
    waited = 0;
    while (!(mb_h == 10 && mb_v == 3) && waited < 400) begin
      tick();
      waited++;
    end
    check("reset_point_reached", 32'(waited < 400), 32'd1);
    check("pre_reset_blank_b", 32'(blk_b), 32'd0);
    reset = 1'b1;
    tick();
    check("mid_rst_blank_b", 32'(blk_b), 32'd1);
    check("mid_rst_r_b", 32'(r_b), 32'd0);
    check("mid_rst_vga_hs_b", 32'(vhs_b), 32'd0);
    check("mid_rst_h_b", 32'(hc_b), 32'd0);
    check("mid_rst_v_b", 32'(vc_b), 32'd0);
    check("mid_rst_blank_a", 32'(blk_a), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    check("release_h_b", 32'(hc_b), 32'd0);
    check("release_v_b", 32'(vc_b), 32'd0);
    tick();
    check("release_step_h_b", 32'(hc_b), 32'd1);
    repeat (60) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scan_out.md
Name: vga_scan_out

Overview:
Downstream output stage of the scan-doubled video path.
- Generates VGA raster timing: 800x525 total, 640x480 active by default.
- Drives the line buffer's read-side counters and syncs: hcount_2, vcount_2, hsync_2, vsync_2.
- Captures the line buffer's registered 3:3:3 pixel data.
- Aligns syncs and blanking to that pixel data through a fixed pipeline and drives the board's VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 96, hsync pulse width in clocks
- H_BP, 48, horizontal back porch in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_POL, 0, asserted level of vga_hsync/vga_vsync (0 = active-low)

Ports:
- pixclk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- hcount  out  12  raster column; feeds line buffer hcount_2
- vcount  out  12  raster line; feeds line buffer vcount_2
- hsync  out  1  raw active-high hsync, stage 0; feeds line buffer hsync_2
- vsync  out  1  raw active-high vsync, stage 0; feeds line buffer vsync_2
- red_in  in  3  line buffer red_2
- grn_in  in  3  line buffer grn_2
- blu_in  in  3  line buffer blu_2
- vga_r  out  3  pin red
- vga_g  out  3  pin green
- vga_b  out  3  pin blue
- vga_hsync  out  1  pin hsync, polarity per SYNC_POL
- vga_vsync  out  1  pin vsync, polarity per SYNC_POL
- vga_blank  out  1  high outside the active area, aligned with vga_r/g/b
- frame_start  out  1  one-cycle pulse, stage 0, when hcount=0 and vcount=0

Behaviour:
- Clocking and reset: clock pixclk; reset is synchronous, active-high.

Counters (stage 0):
- H_TOTAL = sum of the four H parameters; V_TOTAL likewise.
- hcount increments every clock and wraps H_TOTAL-1 -> 0.
- vcount increments only on the hcount wrap, and wraps V_TOTAL-1 -> 0 on that same cycle.
- Both counters are zero-extended to 12 bits.

Decodes (stage 0):
- hsync = 1 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
- vsync = 1 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC.
- active = (hcount < H_ACTIVE) and (vcount < V_ACTIVE).

Output pipeline:
- The line buffer registers read data one clock after the address, so red_in/grn_in/blu_in belong to the previous cycle's stage-0 hcount/vcount.
- hsync, vsync and active are delayed 2 stages.
- vga_r/g/b are registered from red_in/grn_in/blu_in, so they belong to the same stage-0 cycle as the delayed hsync/vsync/active.
- Net result: all pin outputs are exactly 2 clocks behind stage 0 and mutually aligned.

Blanking:
- When the delayed active is 0: vga_r/g/b = 0 and vga_blank = 1.
- Otherwise the colour passes through (see Optional Feature) and vga_blank = 0.

Polarity:
- vga_hsync = delayed hsync XOR ~SYNC_POL; vga_vsync likewise.

Reset state:
- hcount = vcount = 0.
- hsync = vsync = frame_start = 0.
- Delay registers cleared to inactive.
- vga_r/g/b = 0, vga_blank = 1, vga_hsync/vga_vsync at their deasserted level.
- Reset mid-frame: all of the above on the next edge; counting restarts at 0,0 on the first clock with reset low. No partial sync pulse is emitted during reset.

Boundaries:
- At the frame wrap (799,524 -> 0,0), frame_start is asserted while hcount=0, vcount=0.
- hsync is asserted on every line, including vblank lines.

Optional Feature:
- Macro: SCANLINE_EN.
- Defined: on pixels whose 2-stage-delayed vcount[0] = 1, each colour channel is output as (in >> 1). This darkens alternate doubled lines.
- Not defined: colour passes through unchanged; the delayed vcount[0] is not built.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the default 640x480@60 timing constants;
  - H_TOTAL/V_TOTAL derivation functions;
  - the rgb333 typedef (3 x 3-bit struct).
- One natural sub-module, vga_raster_counter: h/v counters plus stage-0 hsync/vsync/active/frame_start decode.
- The top level adds the alignment pipeline, blanking, polarity and the optional scanline logic.

Test Plan:
1. Release reset -> hcount 0..799 then wrap; vcount steps 0->1 on the clock hcount returns to 0; after 525 lines vcount returns to 0 with frame_start high for exactly 1 clock.
2. Count raw hsync per line -> high for hcount 656..751 (96 clocks); raw vsync high for vcount 490..491; with SYNC_POL=0, vga_hsync is low for the same 96 clocks, 2 clocks later.
3. Drive red_in = hcount[2:0] delayed 1 clock (a line buffer model) -> vga_r matches the value for hcount N at cycle N+2; vga_blank falls exactly when that pixel is hcount 0 and rises at hcount 640.
4. Drive constant rgb=7/7/7 -> vga_r/g/b = 0 during hcount 640..799 and vcount 480..524 (2-clock shifted); 7/7/7 elsewhere.
5. Assert reset for 3 clocks at hcount=300, vcount=200 -> pins go to blank and deasserted sync on the next edge; hcount=0, vcount=0 on the first clock after release.
6. With SCANLINE_EN, input 7/6/5 -> line 0 outputs 7/6/5 and line 1 outputs 3/3/2; without the macro, both lines output 7/6/5.
